// File: rtl/cfg_mux_bank.sv
// Bank of NUM_MUX configurable NUM_IN:1 routing muxes with shadow/active select
// registers, atomic commit, sequenced shadow clear and registered readback.

module cfg_mux_lane #(
    parameter int NUM_IN  = 16,
    parameter int SEL_W   = 4,
    parameter int OUT_REG = 0
) (
    input  logic              CLK,
    input  logic              resetn,
    input  logic              i_sh_we,
    input  logic [SEL_W-1:0]  i_sh_wdata,
    input  logic              i_commit,
    input  logic [NUM_IN-1:0] i_in,
    output logic [SEL_W-1:0]  o_shadow,
    output logic [SEL_W-1:0]  o_active,
    output logic              o_out
);
    logic [SEL_W-1:0] r_shadow;
    logic [SEL_W-1:0] r_active;
    logic [SEL_W-1:0] w_sh_next;
    logic             w_mux;

    // Commit copies the post-write shadow so a same-cycle write is included.
    assign w_sh_next = i_sh_we ? i_sh_wdata : r_shadow;
    assign w_mux     = i_in[r_active];
    assign o_shadow  = r_shadow;
    assign o_active  = r_active;

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_shadow <= '0;
            r_active <= '0;
        end else begin
            r_shadow <= w_sh_next;
            if (i_commit) r_active <= w_sh_next;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic r_out;
            always_ff @(posedge CLK or negedge resetn) begin
                if (!resetn) r_out <= 1'b0;
                else         r_out <= w_mux;
            end
            assign o_out = r_out;
        end else begin : g_comb
            assign o_out = w_mux;
        end
    endgenerate
endmodule

module cfg_mux_bank #(
    parameter  int NUM_MUX = 8,
    parameter  int NUM_IN  = 16,
    parameter  int OUT_REG = 0,
    localparam int SEL_W   = $clog2(NUM_IN),
    localparam int AW      = (NUM_MUX > 1) ? $clog2(NUM_MUX) : 1
) (
    input  logic                      CLK,
    input  logic                      resetn,
    input  logic                      cfg_we,
    input  logic [AW-1:0]             cfg_addr,
    input  logic [SEL_W-1:0]          cfg_wdata,
    input  logic                      commit,
    input  logic                      clear,
    input  logic [AW-1:0]             rd_addr,
    output logic [SEL_W-1:0]          rd_data,
    output logic [SEL_W-1:0]          rd_active,
    output logic                      busy,
    output logic                      cfg_err,
    input  logic [NUM_MUX*NUM_IN-1:0] mux_in,
    output logic [NUM_MUX-1:0]        mux_out
);
    localparam logic [AW:0]   LIM  = (AW+1)'(NUM_MUX);
    localparam logic [AW-1:0] LAST = (AW)'(NUM_MUX - 1);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t                        r_state, w_state_nx;
    logic [AW-1:0]                 r_idx, w_idx_nx;
    logic                          r_commit_pending, w_pend_nx;
    logic                          r_cfg_err;
    logic [SEL_W-1:0]              r_rd_data, r_rd_active;
    logic                          w_idle, w_clr, w_addr_ok, w_do_commit, w_err_set;
    logic [NUM_MUX-1:0]            w_sh_we;
    logic [SEL_W-1:0]              w_sh_wdata;
    logic [NUM_MUX-1:0][SEL_W-1:0] w_shadow, w_active;
    logic [SEL_W-1:0]              w_rd_sh, w_rd_act;

    assign w_idle      = (r_state == S_IDLE);
    assign w_clr       = (r_state == S_CLEAR);
    assign w_addr_ok   = ({1'b0, cfg_addr} < LIM);
    assign w_err_set   = cfg_we && (w_clr || !w_addr_ok);
    // A commit deferred by CLEAR fires on the first IDLE cycle, like a fresh pulse.
    assign w_do_commit = w_idle && (commit || r_commit_pending);
    assign w_sh_wdata  = w_clr ? '0 : cfg_wdata;

    genvar k;
    generate
        for (k = 0; k < NUM_MUX; k++) begin : g_lane
            assign w_sh_we[k] = w_clr ? (r_idx == (AW)'(k))
                                      : (cfg_we && w_addr_ok && (cfg_addr == (AW)'(k)));
            cfg_mux_lane #(
                .NUM_IN (NUM_IN),
                .SEL_W  (SEL_W),
                .OUT_REG(OUT_REG)
            ) u_lane (
                .CLK       (CLK),
                .resetn    (resetn),
                .i_sh_we   (w_sh_we[k]),
                .i_sh_wdata(w_sh_wdata),
                .i_commit  (w_do_commit),
                .i_in      (mux_in[k*NUM_IN +: NUM_IN]),
                .o_shadow  (w_shadow[k]),
                .o_active  (w_active[k]),
                .o_out     (mux_out[k])
            );
        end
    endgenerate

    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_pend_nx  = r_commit_pending;
        case (r_state)
            S_IDLE: begin
                w_pend_nx = 1'b0;
                if (clear) begin
                    w_state_nx = S_CLEAR;
                    w_idx_nx   = '0;
                end
            end
            S_CLEAR: begin
                if (commit) w_pend_nx = 1'b1;
                if (r_idx == LAST) begin
                    w_state_nx = S_IDLE;
                    w_idx_nx   = '0;
                end else begin
                    w_idx_nx = r_idx + 1'b1;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_state          <= S_IDLE;
            r_idx            <= '0;
            r_commit_pending <= 1'b0;
            r_cfg_err        <= 1'b0;
        end else begin
            r_state          <= w_state_nx;
            r_idx            <= w_idx_nx;
            r_commit_pending <= w_pend_nx;
            if (w_err_set) r_cfg_err <= 1'b1;
        end
    end

    // Out-of-range read addresses match no lane and fall through to zero.
    always_comb begin
        w_rd_sh  = '0;
        w_rd_act = '0;
        for (int i = 0; i < NUM_MUX; i++) begin
            if (rd_addr == (AW)'(i)) begin
                w_rd_sh  = w_shadow[i];
                w_rd_act = w_active[i];
            end
        end
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_rd_data   <= '0;
            r_rd_active <= '0;
        end else begin
            r_rd_data   <= w_rd_sh;
            r_rd_active <= w_rd_act;
        end
    end

    assign rd_data   = r_rd_data;
    assign rd_active = r_rd_active;
    assign busy      = w_clr;
    assign cfg_err   = r_cfg_err;
endmodule

// File: doc/cfg_mux_bank.md
Name: cfg_mux_bank

Overview:
- Parametrised bank of NUM_MUX configurable NUM_IN:1 routing multiplexers. It generalises the fixed 4:1 and 16:1 fabric muxes, whose selects are driven by per-bit configuration latches.
- Select values are written into a shadow register file through an addressed config port. A commit copies all shadows to the active selects in one cycle, so the routing switches glitch-free.
- A sequenced CLEAR operation and a readback path are included. Sits inside tile switch matrices, between the frame-config logic and the routing nets.

Parameters:
- NUM_MUX, 8, number of independent muxes (1..64)
- NUM_IN, 16, inputs per mux; power of two, 2..32
- SEL_W, $clog2(NUM_IN), select width; derived, do not override
- AW, $clog2(NUM_MUX) (minimum 1), config address width; derived
- OUT_REG, 0, 0 = combinational mux outputs; 1 = outputs registered on CLK

Ports:
- CLK  in  1  fabric clock
- resetn  in  1  asynchronous active-low reset
- cfg_we  in  1  write strobe for the shadow entry at cfg_addr
- cfg_addr  in  AW  shadow entry index
- cfg_wdata  in  SEL_W  select value to write
- commit  in  1  single-cycle pulse: copy all shadows to the active selects
- clear  in  1  single-cycle pulse: start the sequenced zeroing of all shadows
- rd_addr  in  AW  readback index
- rd_data  out  SEL_W  registered readback of the shadow entry at rd_addr
- rd_active  out  SEL_W  registered readback of the active entry at rd_addr
- busy  out  1  high while CLEAR is in progress
- cfg_err  out  1  sticky error flag; cleared only by reset
- mux_in  in  NUM_MUX*NUM_IN  input vector; mux k uses bits [k*NUM_IN +: NUM_IN]
- mux_out  out  NUM_MUX  output vector; bit k = mux_in[k*NUM_IN + active_sel[k]]

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous, active-low, on resetn.
- Reset values:
  - all shadow and active selects = 0
  - rd_data, rd_active = 0; busy = 0; cfg_err = 0; commit_pending = 0; FSM = IDLE
  - OUT_REG=1: mux_out = 0
  - OUT_REG=0: mux_out follows input 0 of each mux
- Write:
  - cfg_we with cfg_addr < NUM_MUX in IDLE updates the shadow on the next CLK edge.
  - Active selects are unaffected until a commit.
  - cfg_addr >= NUM_MUX: write dropped, cfg_err set.
- Commit in IDLE:
  - All active selects take the shadow values at the same edge.
  - If cfg_we is asserted in the same cycle, the written value is included in that commit (write-then-copy).
- Output latency:
  - OUT_REG=0: mux_out reflects the new select combinationally after the commit edge.
  - OUT_REG=1: mux_out changes one edge after the commit edge. mux_in to mux_out latency is 1 cycle.
- FSM states: IDLE and CLEAR.
  - IDLE -> CLEAR on clear=1. Index counter is loaded with 0 and busy=1 from the next cycle.
  - In CLEAR, shadow[idx] is set to 0 and idx increments, one entry per cycle. Entry 0 is cleared on the first CLEAR cycle, so NUM_MUX cycles are spent in CLEAR.
  - CLEAR -> IDLE after entry NUM_MUX-1 is written; busy falls on that same edge.
  - clear in the same cycle as commit in IDLE: commit executes with the pre-clear shadows, then CLEAR starts.
- During CLEAR:
  - cfg_we is dropped and sets cfg_err.
  - commit sets commit_pending. The pending commit executes on the first IDLE cycle after CLEAR, copying the cleared shadows.
  - clear pulses are ignored; no error.
  - Active selects are never modified by CLEAR itself.
- Readback:
  - rd_data and rd_active are registered: they present the values at rd_addr as of the previous edge.
  - rd_addr >= NUM_MUX returns 0; no error.
- Reset mid-operation: reset mid-CLEAR aborts it and clears commit_pending; all state returns to reset values immediately (asynchronous).
- Illegal selects: none can occur, since NUM_IN is a power of two.

Test Plan:
- Reset check: NUM_MUX=8, NUM_IN=16, OUT_REG=0. Hold resetn=0, drive mux_in with a walking pattern -> mux_out[k] = mux_in[k*16]; busy=0; cfg_err=0; rd_data=0.
- Shadow isolation and commit: write shadow[3]=5 and shadow[7]=15, with no commit for 4 cycles -> mux_out unchanged and rd_data(3)=5. Pulse commit -> mux_out[3]=mux_in[53], mux_out[7]=mux_in[127]; rd_active(3)=5 two cycles later.
- Same-cycle write and commit: cfg_we to addr 2 with value 9 together with commit -> rd_active(2)=9. Repeat with OUT_REG=1 -> mux_out[2] updates exactly 1 edge after the commit edge.
- CLEAR with deferred commit: shadows all nonzero; pulse clear, then pulse commit 3 cycles later; issue cfg_we at cycle 4 -> busy high for 8 cycles, cfg_err=1, actives unchanged during CLEAR. First IDLE cycle: all actives=0 and mux_out[k]=mux_in[k*16].
- Address error: cfg_we with cfg_addr=9 on a NUM_MUX=10 build (AW=4, addr 9 valid) -> no error; then cfg_addr=12 -> cfg_err=1, no shadow changed, and cfg_err stays 1 until resetn.
- Async reset mid-CLEAR: assert resetn=0 on CLEAR cycle 3, between clock edges -> busy=0 immediately; all selects=0; after release, commit with no writes keeps all actives=0.
